// File: rtl/branch_ctrl.sv
// EX-stage branch resolver: same-cycle accept once operands are ready, 1-cycle registered redirect/flush for taken branches.
// Stalls the front end while operands are pending; branch/taken statistics counters saturate.
module branch_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  input  logic             jump,
  input  logic [2:0]       br_funct3,
  input  logic             opnd_ready,
  input  logic             BrEq,
  input  logic             BrLt,
  input  logic [XLEN-1:0]  target,
  output logic             BrUn,
  output logic             stall,
  output logic             br_accept,
  output logic             illegal,
  output logic             pc_sel,
  output logic             flush,
  output logic [XLEN-1:0]  pc_target,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_branches,
  output logic [CNT_W-1:0] cnt_taken
);

  typedef enum logic [1:0] {IDLE, WAIT, REDIRECT} state_e;

  state_e            state_q, state_d;
  logic              taken, active, resolve, bad_f3, count_br;
  logic              pc_sel_q, flush_q;
  logic [XLEN-1:0]   pc_target_q, pc_target_d;
  logic [CNT_W-1:0]  cnt_br_q, cnt_br_d, cnt_tk_q, cnt_tk_d;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_comb begin
    taken = 1'b0;
    if (jump) begin
      taken = 1'b1;
    end else begin
      case (br_funct3)
        3'b000:         taken = BrEq;
        3'b001:         taken = ~BrEq;
        3'b100, 3'b110: taken = BrLt;
        3'b101, 3'b111: taken = ~BrLt;
        default:        taken = 1'b0;
      endcase
    end
  end

  // A branch seen during REDIRECT is on the wrong path and must not act at all.
  assign active    = br_valid & (state_q != REDIRECT);
  assign resolve   = active & opnd_ready;
  assign bad_f3    = (br_funct3[2:1] == 2'b01);
  assign count_br  = resolve & ~jump & ~bad_f3;

  assign BrUn      = br_funct3[1] & ~jump;
  assign stall     = active & ~opnd_ready;
  assign br_accept = resolve;
  assign illegal   = resolve & ~jump & bad_f3;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, WAIT: begin
        if (!br_valid)       state_d = IDLE;
        else if (opnd_ready) state_d = taken ? REDIRECT : IDLE;
        else                 state_d = WAIT;
      end
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_target_d = pc_target_q;
    if (resolve && taken) pc_target_d = target;

    cnt_br_d = cnt_br_q;
    cnt_tk_d = cnt_tk_q;
    if (cnt_clr) begin
      cnt_br_d = '0;
      cnt_tk_d = '0;
    end else if (count_br) begin
      if (!(&cnt_br_q))           cnt_br_d = cnt_br_q + ONE;
      if (taken && !(&cnt_tk_q))  cnt_tk_d = cnt_tk_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_sel_q    <= 1'b0;
      flush_q     <= 1'b0;
      pc_target_q <= '0;
      cnt_br_q    <= '0;
      cnt_tk_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_sel_q    <= (state_d == REDIRECT);
      flush_q     <= (state_d == REDIRECT);
      pc_target_q <= pc_target_d;
      cnt_br_q    <= cnt_br_d;
      cnt_tk_q    <= cnt_tk_d;
    end
  end

  assign pc_sel       = pc_sel_q;
  assign flush        = flush_q;
  assign pc_target    = pc_target_q;
  assign cnt_branches = cnt_br_q;
  assign cnt_taken    = cnt_tk_q;

endmodule
